// File: rtl/weight_loader_if.sv
// Stream-in / memory-write-out bundle for weight_loader.
// The slave modport faces the loader, the master modport faces the producer and observer.
interface weight_loader_if #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  s_valid;
  logic [WIDTH-1:0]      s_data;
  logic                  s_ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      checksum;

  modport master (
    output start, base_addr, length, s_valid, s_data,
    input  s_ready, we, waddr, wdata, busy, done, checksum
  );

  modport slave (
    input  start, base_addr, length, s_valid, s_data,
    output s_ready, we, waddr, wdata, busy, done, checksum
  );
endinterface

// File: rtl/weight_loader.sv
// Streams valid/ready words into a single-port memory at a wrapping sequential address.
// Define WEIGHT_LOADER_CHECKSUM_EN to build the running modulo-2^WIDTH checksum.
module weight_loader #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  weight_loader_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  hs;
  logic                  start_acc;

  assign hs        = (state_q == LOAD) && bus.s_valid;
  assign start_acc = (state_q == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = bus.base_addr;
            rem_d   = (bus.length > DEPTH_L) ? DEPTH_L : bus.length;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = bus.s_data;
          // explicit compare keeps the wrap correct for non-power-of-2 DEPTH
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == (ADDR_WIDTH + 1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  always_comb begin
    csum_d = csum_q;
    if (start_acc)  csum_d = '0;
    else if (hs)    csum_d = csum_q + bus.s_data;
  end

  assign bus.checksum = csum_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign bus.checksum     = '0;
`endif

  assign bus.s_ready = (state_q == LOAD);
  assign bus.busy    = (state_q == LOAD);
  assign bus.we      = we_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: predicted writes are queued as beats are driven
// and matched against we/waddr/wdata/done on the falling edge.
module tb_weight_loader;
  localparam int DEPTH = 64;
  localparam int WIDTH = 32;
  localparam int AW    = $clog2(DEPTH);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_loader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  weight_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             last;
  } wr_t;

  wr_t sb[$];
  int  checks    = 0;
  int  failures  = 0;
  bit  zero_pend = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.we) begin
      if (sb.size() == 0) begin
        check("we_unexpected", 64'd1, 64'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("waddr", 64'(bus.waddr), 64'(e.addr));
        check("wdata", 64'(bus.wdata), 64'(e.data));
        check("done_with_we", 64'(bus.done), 64'(e.last));
      end
    end else if (bus.done) begin
      check("done_zero_len", 64'(zero_pend), 64'd1);
      zero_pend = 1'b0;
    end
  end

  // Drives one load; vlen==0 means s_valid held high, otherwise vpat bits (LSB first) repeat.
  task automatic do_load(input int base, input int len, input int mul,
                         input logic [7:0] vpat, input int vlen,
                         input int inject_at, input int abort_at);
    int               eff;
    int               addr;
    int               i;
    int               cyc;
    bit               v;
    bit               prev_v;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] csum;
    logic [AW-1:0]    la;
    logic [WIDTH-1:0] ld;
    eff    = (len > DEPTH) ? DEPTH : len;
    addr   = base;
    i      = 0;
    cyc    = 0;
    prev_v = 1'b1;
    csum   = '0;
    la     = '0;
    ld     = '0;
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.length    = (AW + 1)'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_rise", 64'(bus.busy), 64'd1);
    while (i < eff) begin
      check("s_ready_load", 64'(bus.s_ready), 64'd1);
      if (!prev_v && i > 0) begin
        check("we_idle_gap", 64'(bus.we), 64'd0);
        check("waddr_hold", 64'(bus.waddr), 64'(la));
        check("wdata_hold", 64'(bus.wdata), 64'(ld));
      end
      v = (vlen == 0) ? 1'b1 : vpat[cyc % vlen];
      d = WIDTH'(mul * (i + 1));
      if (cyc == inject_at) begin
        bus.start     = 1'b1;
        bus.base_addr = AW'(5);
        bus.length    = (AW + 1)'(3);
      end else begin
        bus.start = 1'b0;
      end
      if (i == abort_at) begin
        rst         = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_checksum", 64'(bus.checksum), 64'd0);
        return;
      end
      bus.s_valid = v;
      bus.s_data  = d;
      if (v) begin
        sb.push_back('{AW'(addr), d, (i == eff - 1)});
        csum += d;
        la   = AW'(addr);
        ld   = d;
        addr = (addr == DEPTH - 1) ? 0 : addr + 1;
        i++;
      end
      prev_v = v;
      cyc++;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.start   = 1'b0;
    check("done_final", 64'(bus.done), 64'd1);
    check("busy_fall", 64'(bus.busy), 64'd0);
    check("checksum", 64'(bus.checksum), CSUM_ON ? 64'(csum) : 64'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("idle_s_ready", 64'(bus.s_ready), 64'd0);
  endtask

  task automatic zero_load();
    bus.start     = 1'b1;
    bus.base_addr = AW'(7);
    bus.length    = '0;
    zero_pend     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("zl_done", 64'(bus.done), 64'd1);
    check("zl_busy", 64'(bus.busy), 64'd0);
    check("zl_we", 64'(bus.we), 64'd0);
    check("zl_s_ready", 64'(bus.s_ready), 64'd0);
    @(posedge clk); #1;
    check("zl_done_low", 64'(bus.done), 64'd0);
    check("zl_busy_low", 64'(bus.busy), 64'd0);
    check("zl_seen", 64'(zero_pend), 64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_we", 64'(bus.we), 64'd0);
    check("reset_waddr", 64'(bus.waddr), 64'd0);
    check("reset_wdata", 64'(bus.wdata), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_s_ready", 64'(bus.s_ready), 64'd0);
    check("reset_checksum", 64'(bus.checksum), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_load(0, 4, 'h11, 8'h00, 0, -1, -1);
    do_load(62, 4, 1, 8'h00, 0, -1, -1);
    do_load(10, 3, 7, 8'b0001_1001, 5, -1, -1);
    zero_load();
    do_load(20, 100, 3, 8'h00, 0, 10, -1);
    do_load(40, 5, 2, 8'h00, 0, -1, 2);
    do_load(33, 5, 5, 8'h00, 0, -1, -1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
# weight_loader

Streaming writer that fills a synchronous single-port weight/coefficient memory from a valid/ready word stream. It is the write-side counterpart of the LSTM read-only weight memories: it issues one-cycle write strobes with a sequentially incrementing, wrapping address. Its write port drives memory write ports so that weights can be reloaded at runtime instead of only through init files.

## Interface
Parameters:
- DEPTH, 64, number of memory words addressed
- WIDTH, 32, data word width in bits
- ADDR_WIDTH, $clog2(DEPTH), localparam, address width

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous active-high reset; one clock, synchronous and active-high reset
- start  input  1  single-cycle load request; sampled only in IDLE
- base_addr  input  ADDR_WIDTH  first write address, captured on start
- length  input  ADDR_WIDTH+1  words to load, captured on start; values above DEPTH clamp to DEPTH
- s_valid  input  1  stream word valid
- s_data  input  WIDTH  stream word
- s_ready  output  1  stream ready; equal to (state == LOAD), combinational from state only
- we  output  1  registered memory write enable
- waddr  output  ADDR_WIDTH  registered write address
- wdata  output  WIDTH  registered write data
- busy  output  1  high while in LOAD
- done  output  1  one-cycle completion pulse
- checksum  output  WIDTH  modulo-2^WIDTH sum of loaded words; see Configuration

## Operation
- States: IDLE, LOAD.
- IDLE: when start=1 and length=0, no state change and done=1 on the next cycle.
- IDLE: when start=1 and length>0, capture addr=base_addr and remaining=min(length,DEPTH), clear checksum, go to LOAD.
- LOAD: s_ready=1. A handshake is s_valid&&s_ready. On a handshake:
  - register we=1, waddr=addr, wdata=s_data;
  - addr increments; it wraps to 0 after DEPTH-1, including for non-power-of-2 DEPTH;
  - remaining decrements.
- LOAD: on the handshake with remaining=1, go to IDLE and register done=1 (done coincides with the final we).
- Cycles without a handshake register we=0. waddr and wdata hold their previous values.
- start while in LOAD is ignored. Captured parameters are not altered.
- A single load of length DEPTH starting at nonzero base_addr wraps and writes every location exactly once.
- Reset: state=IDLE. we, waddr, wdata, busy, done and checksum are all 0, and s_ready=0. An in-flight load is abandoned. A beat presented in the reset cycle is not consumed.

## Timing
- Write latency: the accepted beat appears on we/waddr/wdata exactly 1 cycle after its handshake edge.
- Throughput: 1 word/cycle with s_valid held high. A load of N words occupies N LOAD cycles.
- busy rises in the cycle after start and falls in the cycle where done=1.
- done is high for exactly one cycle. A new start is accepted in the same cycle that done is high (state is IDLE).
- The earliest next handshake after done is 1 cycle after that start is sampled.
- s_ready has no combinational dependence on s_valid.

## Configuration
- WEIGHT_LOADER_CHECKSUM_EN defined:
  - the checksum register accumulates s_data on every handshake, modulo 2^WIDTH;
  - it is cleared on accepted start and on rst;
  - it is stable and valid from the done cycle until the next accepted start.
- Not defined: the checksum port is present but tied to 0, and no accumulator logic is built.

## Test plan
- rst, then start with base_addr=0, length=4, and s_valid constant with data 0x11,0x22,0x33,0x44 -> we high for 4 consecutive cycles writing addrs 0..3 with those data; done pulses with the 4th write; busy low afterwards.
- DEPTH=64, base_addr=62, length=4 -> writes to addrs 62,63,0,1; with CHECKSUM_EN and data 1,2,3,4, checksum=10 at done.
- s_valid toggling 1,0,0,1,1 during length=3 -> we only in the cycle after each handshake; waddr and wdata hold between writes; done on the 3rd write.
- start with length=0 -> no we; done high exactly 1 cycle after start; busy stays 0.
- length=100 with DEPTH=64 -> exactly 64 writes, each address once, then done; an extra start mid-load is ignored.
- rst asserted after 2 of 5 words -> next cycle: we=0, busy=0, done=0, s_ready=0, checksum=0; a fresh start then loads normally from its own base_addr.
